line_buffer_ctrl: RTL and testbench

Sequencer for the ping_pong_ram line buffer in the SC130GS camera-to-HDMI pipeline.
- Converts a raster pixel stream (vsync/de/data) into ping_pong_ram write/read addressing and line_end swap pulses.
- Emits each current-line pixel aligned with the co-located pixel of the previous line, for vertical 3x1/3x3 filters downstream.
- Tracks line count and line width and flags protocol errors.

---
 rtl/line_buffer_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_line_buffer_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// line_buffer_ctrl
//
// Sequencer for the ping_pong_ram line buffer. It turns a raster pixel stream
// (vsync/de/data) into RAM write/read addressing plus a one-cycle line_end
// swap pulse. Each current-line pixel comes out next to the pixel at the same
// column of the previous line, so vertical filters downstream get aligned
// taps. It also tracks line count and line width and flags protocol errors.
//
// Optional build macro:
//   LBC_FIRST_LINE_ZERO_EN - when defined, out_prev reads as 0 while
//                            out_first_line is high (no stale RAM data on
//                            line 0 of a frame).
//
// Ports:
//   clk            in   pixel clock
//   reset          in   synchronous, active-high reset
//   in_vsync       in   frame start level; rising edge starts a new frame
//   in_de          in   pixel valid, high for the whole active line
//   in_data        in   pixel
//   ram_we         out  RAM write enable
//   ram_waddr      out  RAM write address
//   ram_wdata      out  RAM write data
//   ram_re         out  RAM read enable
//   ram_raddr      out  RAM read address
//   ram_line_end   out  one-cycle bank swap pulse
//   ram_rdata      in   RAM read data, 1-cycle latency
//   out_de         out  aligned output valid
//   out_cur        out  current-line pixel
//   out_prev       out  previous-line pixel at the same column
//   out_first_line out  out_de belongs to line 0 of the frame
//   line_cnt       out  index of the line being written (saturating)
//   line_width     out  pixel count of the last completed line
//   err_ovf        out  sticky: pixels dropped beyond MAX_WIDTH
//   err_blank      out  sticky: in_de high during the line_end cycle
// ---------------------------------------------------------------------------
module line_buffer_ctrl #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 11,
    parameter int ADDR_BASE = 1,
    parameter int MAX_WIDTH = 1280
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_vsync,
    input  logic              in_de,
    input  logic [DATA_W-1:0] in_data,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_re,
    output logic [ADDR_W-1:0] ram_raddr,
    output logic              ram_line_end,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              out_de,
    output logic [DATA_W-1:0] out_cur,
    output logic [DATA_W-1:0] out_prev,
    output logic              out_first_line,
    output logic [ADDR_W-1:0] line_cnt,
    output logic [ADDR_W-1:0] line_width,
    output logic              err_ovf,
    output logic              err_blank
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        SWAP   = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(ADDR_BASE);
    localparam logic [ADDR_W-1:0] MAX_CNT   = ADDR_W'(MAX_WIDTH);
    localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

    state_t              state_q;
    logic                vsync_q;
    logic [ADDR_W-1:0]   cnt_q;          // pixels accepted in the current line
    logic [ADDR_W-1:0]   line_cnt_q;
    logic [ADDR_W-1:0]   line_width_q;
    logic                err_ovf_q;
    logic                err_blank_q;
    logic                first_q;        // line being written is line 0
    logic                out_de_q;
    logic [DATA_W-1:0]   out_cur_q;
    logic                out_first_line_q;

    logic                vsync_rise;
    logic                full;
    logic                accept;
    logic [ADDR_W-1:0]   col_addr;

    assign vsync_rise = in_vsync & ~vsync_q;
    assign full       = (cnt_q == MAX_CNT);

    // A frame start wins over everything, so the pixel in that cycle is
    // dropped; pixels during SWAP or past MAX_WIDTH are dropped as well.
    assign accept = in_de & ~vsync_rise &
                    ((state_q == IDLE) || ((state_q == ACTIVE) && !full));

    assign col_addr = BASE_ADDR + cnt_q;

    // Write and read share the column address: the write lands in one bank
    // while the read fetches the previous line from the other bank.
    assign ram_we       = accept;
    assign ram_re       = accept;
    assign ram_waddr    = col_addr;
    assign ram_raddr    = col_addr;
    assign ram_wdata    = in_data;
    assign ram_line_end = (state_q == SWAP);

    assign out_de         = out_de_q;
    assign out_cur        = out_cur_q;
    assign out_first_line = out_first_line_q;
    assign line_cnt       = line_cnt_q;
    assign line_width     = line_width_q;
    assign err_ovf        = err_ovf_q;
    assign err_blank      = err_blank_q;

    // ram_rdata arrives one cycle after the read, i.e. together with the
    // registered current pixel, so it is passed straight through.
`ifdef LBC_FIRST_LINE_ZERO_EN
    assign out_prev = out_first_line_q ? '0 : ram_rdata;
`else
    assign out_prev = ram_rdata;
`endif

    // NOTE: all state here is sequential, so every assignment uses <=; a
    // blocking assignment would let later statements see the new value.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            vsync_q          <= 1'b0;
            cnt_q            <= '0;
            line_cnt_q       <= '0;
            line_width_q     <= '0;
            err_ovf_q        <= 1'b0;
            err_blank_q      <= 1'b0;
            first_q          <= 1'b0;
            out_de_q         <= 1'b0;
            out_cur_q        <= '0;
            out_first_line_q <= 1'b0;
        end else begin
            vsync_q          <= in_vsync;
            out_de_q         <= accept;
            out_cur_q        <= in_data;
            out_first_line_q <= accept & first_q;

            if (vsync_rise) begin
                // Abandon whatever line is in flight without a swap pulse;
                // sticky errors survive across frames.
                state_q    <= IDLE;
                cnt_q      <= '0;
                line_cnt_q <= '0;
                first_q    <= 1'b1;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (in_de) begin
                            state_q <= ACTIVE;
                            cnt_q   <= cnt_q + ONE;
                        end
                    end
                    ACTIVE: begin
                        if (in_de) begin
                            if (full) begin
                                err_ovf_q <= 1'b1;
                            end else begin
                                cnt_q <= cnt_q + ONE;
                            end
                        end else begin
                            line_width_q <= cnt_q;
                            cnt_q        <= '0;
                            state_q      <= SWAP;
                        end
                    end
                    SWAP: begin
                        if (in_de) begin
                            err_blank_q <= 1'b1;
                        end
                        if (line_cnt_q != '1) begin
                            line_cnt_q <= line_cnt_q + ONE;
                        end
                        first_q <= 1'b0;
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_line_buffer_ctrl
//
// Directed bench for line_buffer_ctrl. Instance "a" uses the default
// parameters and is backed by a small ping-pong RAM model; instance "b" has
// MAX_WIDTH=4 to exercise the overflow path and shares the same stimulus.
// Inputs change 1 time unit after a rising edge; outputs are sampled 1 time
// unit later, well clear of the next rising edge.
// ---------------------------------------------------------------------------
module tb_line_buffer_ctrl;

    localparam int DW = 8;
    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_vsync;
    logic          in_de;
    logic [DW-1:0] in_data;

    logic          a_we, a_re, a_line_end, a_out_de, a_first, a_err_ovf, a_err_blank;
    logic [AW-1:0] a_waddr, a_raddr, a_line_cnt, a_line_width;
    logic [DW-1:0] a_wdata, a_rdata, a_out_cur, a_out_prev;

    logic          b_we, b_re, b_line_end, b_out_de, b_first, b_err_ovf, b_err_blank;
    logic [AW-1:0] b_waddr, b_raddr, b_line_cnt, b_line_width;
    logic [DW-1:0] b_wdata, b_out_cur, b_out_prev;
    logic [DW-1:0] b_rdata = '0;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    always #5 clk = ~clk;

    line_buffer_ctrl dut_a (
        .clk(clk), .reset(reset), .in_vsync(in_vsync), .in_de(in_de), .in_data(in_data),
        .ram_we(a_we), .ram_waddr(a_waddr), .ram_wdata(a_wdata), .ram_re(a_re),
        .ram_raddr(a_raddr), .ram_line_end(a_line_end), .ram_rdata(a_rdata),
        .out_de(a_out_de), .out_cur(a_out_cur), .out_prev(a_out_prev),
        .out_first_line(a_first), .line_cnt(a_line_cnt), .line_width(a_line_width),
        .err_ovf(a_err_ovf), .err_blank(a_err_blank)
    );

    line_buffer_ctrl #(.MAX_WIDTH(4)) dut_b (
        .clk(clk), .reset(reset), .in_vsync(in_vsync), .in_de(in_de), .in_data(in_data),
        .ram_we(b_we), .ram_waddr(b_waddr), .ram_wdata(b_wdata), .ram_re(b_re),
        .ram_raddr(b_raddr), .ram_line_end(b_line_end), .ram_rdata(b_rdata),
        .out_de(b_out_de), .out_cur(b_out_cur), .out_prev(b_out_prev),
        .out_first_line(b_first), .line_cnt(b_line_cnt), .line_width(b_line_width),
        .err_ovf(b_err_ovf), .err_blank(b_err_blank)
    );

    // Ping-pong RAM model: write bank = sel, read bank = !sel, swap on line_end.
    logic [DW-1:0] bank [2][2**AW];
    logic          sel = 1'b0;

    initial begin
        a_rdata = '0;
        for (int i = 0; i < 2**AW; i++) begin
            bank[0][i] = '0;
            bank[1][i] = '0;
        end
    end

    always @(posedge clk) begin
        if (a_we) bank[sel][a_waddr] <= a_wdata;
        if (a_re) a_rdata <= bank[!sel][a_raddr];
        if (a_line_end) sel <= !sel;
    end

    task automatic set_in(input logic de, input logic [DW-1:0] d, input logic vs);
        in_de    = de;
        in_data  = d;
        in_vsync = vs;
        #1;
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        set_in(1'b0, 8'h00, 1'b0);
        next_cycle();
        next_cycle();
        vec_cnt++;
        if ({a_we, a_re, a_line_end, a_out_de, a_first, a_err_ovf, a_err_blank} !== 7'b0) begin
            miss_cnt++;
            $display("FAIL reset_flags: got %b expected 0000000",
                     {a_we, a_re, a_line_end, a_out_de, a_first, a_err_ovf, a_err_blank});
        end
        vec_cnt++;
        if ({a_waddr, a_raddr} !== {11'd1, 11'd1}) begin
            miss_cnt++;
            $display("FAIL reset_addr: got waddr=%0d raddr=%0d expected 1/1", a_waddr, a_raddr);
        end
        vec_cnt++;
        if ({a_line_cnt, a_line_width, a_out_cur} !== '0) begin
            miss_cnt++;
            $display("FAIL reset_counts: got cnt=%0d width=%0d cur=%h expected 0/0/00",
                     a_line_cnt, a_line_width, a_out_cur);
        end
        reset = 1'b0;
        next_cycle();
    endtask

    task automatic test_vsync_start;
        set_in(1'b0, 8'h00, 1'b1);
        next_cycle();
        set_in(1'b0, 8'h00, 1'b0);
        vec_cnt++;
        if ({a_line_cnt, a_line_end, a_we} !== {11'd0, 1'b0, 1'b0}) begin
            miss_cnt++;
            $display("FAIL vsync_start: got cnt=%0d line_end=%b we=%b expected 0/0/0",
                     a_line_cnt, a_line_end, a_we);
        end
    endtask

    // Four pixels then two blank cycles; px/prev are packed first-pixel-high.
    task automatic test_line(input logic [3:0][DW-1:0] px, input logic [3:0][DW-1:0] prev,
                             input logic first, input logic [AW-1:0] exp_cnt);
        vec_cnt++;
        if (a_line_cnt !== exp_cnt - 11'd1) begin
            miss_cnt++;
            $display("FAIL line_cnt_before: got %0d expected %0d", a_line_cnt, exp_cnt - 11'd1);
        end
        for (int i = 0; i < 6; i++) begin
            int k;
            logic [DW-1:0] exp_px;
            logic [DW-1:0] exp_prev;
            k = (i < 4) ? 3 - i : 0;
            exp_px = px[k];
            set_in(i < 4, (i < 4) ? exp_px : 8'h00, 1'b0);
            vec_cnt++;
            if (i < 4) begin
                if ({a_we, a_re, a_waddr, a_raddr, a_wdata} !==
                    {1'b1, 1'b1, 11'(i + 1), 11'(i + 1), exp_px}) begin
                    miss_cnt++;
                    $display("FAIL write_px%0d: got we=%b re=%b wa=%0d ra=%0d wd=%h expected 1/1/%0d/%0d/%h",
                             i, a_we, a_re, a_waddr, a_raddr, a_wdata, i + 1, i + 1, exp_px);
                end
            end else if ({a_we, a_re} !== 2'b00) begin
                miss_cnt++;
                $display("FAIL blank_we%0d: got we=%b re=%b expected 0/0", i, a_we, a_re);
            end
            vec_cnt++;
            if (a_line_end !== (i == 5)) begin
                miss_cnt++;
                $display("FAIL line_end%0d: got %b expected %b", i, a_line_end, i == 5);
            end
            if (i >= 1 && i <= 4) begin
                k = 4 - i;
                exp_px   = px[k];
                exp_prev = prev[k];
`ifdef LBC_FIRST_LINE_ZERO_EN
                if (first) exp_prev = 8'h00;
`endif
                vec_cnt++;
                if ({a_out_de, a_out_cur, a_first} !== {1'b1, exp_px, first}) begin
                    miss_cnt++;
                    $display("FAIL out_px%0d: got de=%b cur=%h first=%b expected 1/%h/%b",
                             i - 1, a_out_de, a_out_cur, a_first, exp_px, first);
                end
`ifndef LBC_FIRST_LINE_ZERO_EN
                if (!first) begin
`endif
                    vec_cnt++;
                    if (a_out_prev !== exp_prev) begin
                        miss_cnt++;
                        $display("FAIL out_prev%0d: got %h expected %h", i - 1, a_out_prev, exp_prev);
                    end
`ifndef LBC_FIRST_LINE_ZERO_EN
                end
`endif
            end else begin
                vec_cnt++;
                if (a_out_de !== 1'b0) begin
                    miss_cnt++;
                    $display("FAIL out_de_idle%0d: got %b expected 0", i, a_out_de);
                end
            end
            if (i == 5) begin
                vec_cnt++;
                if (a_line_width !== 11'd4) begin
                    miss_cnt++;
                    $display("FAIL line_width: got %0d expected 4", a_line_width);
                end
            end
            next_cycle();
        end
        vec_cnt++;
        if ({a_line_cnt, a_line_end} !== {exp_cnt, 1'b0}) begin
            miss_cnt++;
            $display("FAIL line_cnt_after: got cnt=%0d line_end=%b expected %0d/0",
                     a_line_cnt, a_line_end, exp_cnt);
        end
    endtask

    task automatic test_overflow;
        int de_seen;
        de_seen = 0;
        vec_cnt++;
        if (b_err_ovf !== 1'b0) begin
            miss_cnt++;
            $display("FAIL ovf_before: got %b expected 0", b_err_ovf);
        end
        for (int i = 0; i < 8; i++) begin
            set_in(i < 6, 8'(i + 1), 1'b0);
            if (i < 6) begin
                vec_cnt++;
                if ({b_we, b_re} !== {2{i < 4}}) begin
                    miss_cnt++;
                    $display("FAIL ovf_we%0d: got we=%b re=%b expected %b", i, b_we, b_re, i < 4);
                end
                if (i < 4) begin
                    vec_cnt++;
                    if (b_waddr !== 11'(i + 1)) begin
                        miss_cnt++;
                        $display("FAIL ovf_addr%0d: got %0d expected %0d", i, b_waddr, i + 1);
                    end
                end
            end
            if (b_out_de === 1'b1) de_seen++;
            if (i == 7) begin
                vec_cnt++;
                if ({b_line_end, b_line_width, b_err_ovf} !== {1'b1, 11'd4, 1'b1}) begin
                    miss_cnt++;
                    $display("FAIL ovf_b_end: got line_end=%b width=%0d err_ovf=%b expected 1/4/1",
                             b_line_end, b_line_width, b_err_ovf);
                end
                vec_cnt++;
                if ({a_line_width, a_err_ovf} !== {11'd6, 1'b0}) begin
                    miss_cnt++;
                    $display("FAIL ovf_a_end: got width=%0d err_ovf=%b expected 6/0",
                             a_line_width, a_err_ovf);
                end
            end
            next_cycle();
        end
        vec_cnt++;
        if (de_seen !== 4) begin
            miss_cnt++;
            $display("FAIL ovf_out_de_count: got %0d expected 4", de_seen);
        end
    endtask

    task automatic test_blank;
        vec_cnt++;
        if (a_err_blank !== 1'b0) begin
            miss_cnt++;
            $display("FAIL blank_before: got %b expected 0", a_err_blank);
        end
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 8'(8'hE1 + i), 1'b0);
            next_cycle();
        end
        set_in(1'b0, 8'h00, 1'b0);
        next_cycle();
        // SWAP cycle with de illegally high
        set_in(1'b1, 8'h99, 1'b0);
        vec_cnt++;
        if ({a_line_end, a_we} !== 2'b10) begin
            miss_cnt++;
            $display("FAIL blank_swap: got line_end=%b we=%b expected 1/0", a_line_end, a_we);
        end
        next_cycle();
        set_in(1'b1, 8'h5A, 1'b0);
        vec_cnt++;
        if ({a_we, a_waddr, a_err_blank, a_out_de} !== {1'b1, 11'd1, 1'b1, 1'b0}) begin
            miss_cnt++;
            $display("FAIL blank_next: got we=%b wa=%0d err_blank=%b out_de=%b expected 1/1/1/0",
                     a_we, a_waddr, a_err_blank, a_out_de);
        end
        next_cycle();
        set_in(1'b0, 8'h00, 1'b0);
        vec_cnt++;
        if ({a_out_de, a_out_cur} !== {1'b1, 8'h5A}) begin
            miss_cnt++;
            $display("FAIL blank_out: got de=%b cur=%h expected 1/5a", a_out_de, a_out_cur);
        end
        repeat (3) next_cycle();
    endtask

    task automatic test_vsync_mid;
        set_in(1'b1, 8'hC1, 1'b0);
        next_cycle();
        set_in(1'b1, 8'hC2, 1'b0);
        next_cycle();
        set_in(1'b0, 8'h00, 1'b1);
        vec_cnt++;
        if ({a_we, a_line_end} !== 2'b00) begin
            miss_cnt++;
            $display("FAIL vmid_rise: got we=%b line_end=%b expected 0/0", a_we, a_line_end);
        end
        next_cycle();
        set_in(1'b1, 8'hC4, 1'b1);
        vec_cnt++;
        if ({a_line_end, a_line_cnt, a_we, a_waddr} !== {1'b0, 11'd0, 1'b1, 11'd1}) begin
            miss_cnt++;
            $display("FAIL vmid_restart: got line_end=%b cnt=%0d we=%b wa=%0d expected 0/0/1/1",
                     a_line_end, a_line_cnt, a_we, a_waddr);
        end
        next_cycle();
        set_in(1'b0, 8'h00, 1'b1);
        vec_cnt++;
        if ({a_out_de, a_out_cur, a_first, a_line_end} !== {1'b1, 8'hC4, 1'b1, 1'b0}) begin
            miss_cnt++;
            $display("FAIL vmid_out: got de=%b cur=%h first=%b line_end=%b expected 1/c4/1/0",
                     a_out_de, a_out_cur, a_first, a_line_end);
        end
        vec_cnt++;
        if ({a_err_blank, b_err_ovf} !== 2'b11) begin
            miss_cnt++;
            $display("FAIL vmid_sticky: got err_blank=%b err_ovf=%b expected 1/1", a_err_blank, b_err_ovf);
        end
`ifdef LBC_FIRST_LINE_ZERO_EN
        vec_cnt++;
        if (a_out_prev !== 8'h00) begin
            miss_cnt++;
            $display("FAIL vmid_prev_zero: got %h expected 00", a_out_prev);
        end
`endif
        repeat (3) next_cycle();
        set_in(1'b0, 8'h00, 1'b0);
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_vsync_start();
        test_line({8'hAA, 8'hBB, 8'hCC, 8'hDD}, '0, 1'b1, 11'd1);
        test_line({8'h11, 8'h22, 8'h33, 8'h44}, {8'hAA, 8'hBB, 8'hCC, 8'hDD}, 1'b0, 11'd2);
        test_line({8'h55, 8'h66, 8'h77, 8'h88}, {8'h11, 8'h22, 8'h33, 8'h44}, 1'b0, 11'd3);
        test_overflow();
        test_blank();
        test_vsync_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
